// File: rtl/ifetch_align.sv
// ifetch_align: fetch-side aligner for the BJX1 decoder. Aligned 32-bit words
// from instruction memory are split into a halfword queue, and the decoder sees
// a 32-bit window {hw[head+1], hw[head]} starting at istrPc.
// Optional feature macro: IFETCH_STALL_CNT_EN (enables the stallCnt counter).
module ifetch_align #(
   parameter int          QHW_DEPTH = 8,
   parameter logic [31:0] RESET_PC  = 32'hA000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        memReq,
   output logic [31:0] memAddr,
   input  logic        memAck,
   input  logic [31:0] memData,
   input  logic        memErr,
   output logic [31:0] istrWord,
   output logic        istrValid,
   output logic [31:0] istrPc,
   output logic        istrFault,
   input  logic        idTake,
   input  logic [1:0]  idStepPc,
   input  logic        brValid,
   input  logic [31:0] brAddr,
   output logic [31:0] stallCnt
);

   localparam int          PW      = $clog2(QHW_DEPTH);
   localparam int          CW      = $clog2(QHW_DEPTH + 1);
   localparam int unsigned DEPTH_U = QHW_DEPTH;

   typedef enum logic [1:0] {RUN, FLUSH, FAULT} state_t;

   state_t        state;
   state_t        state_next;
   logic [15:0]   queue [QHW_DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] head_next;
   logic [PW-1:0] head1;
   logic [PW-1:0] tail0;
   logic [PW-1:0] tail1;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [31:0]   pc;
   logic [31:0]   fetch_addr;
   logic          skip_low;
   logic          xfer_ok;
   logic          xfer_err;
   logic          pop_ok;
   logic [1:0]    push_cnt;
   logic [1:0]    pop_cnt;

   // Circular index helper; callers never exceed twice the depth, so one
   // subtraction is enough and non-power-of-two depths still work.
   function automatic logic [PW-1:0] wrap_idx(input int unsigned idx);
      int unsigned w;
      w = (idx >= DEPTH_U) ? idx - DEPTH_U : idx;
      return PW'(w);
   endfunction

   assign istrValid = (count >= CW'(2));
   assign istrWord  = istrValid ? {queue[head1], queue[head]} : 32'd0;
   assign istrPc    = pc;
   assign memAddr   = fetch_addr;
   assign istrFault = (state == FAULT) && !istrValid;

   // Per-edge push/pop amounts, queue indices and the next FSM state.
   always_comb begin
      xfer_ok  = memReq && memAck && !memErr;
      xfer_err = memReq && memAck && memErr;
      push_cnt = 2'd0;
      if (xfer_ok) begin
         push_cnt = skip_low ? 2'd1 : 2'd2;
      end
      pop_ok  = idTake && istrValid;
      pop_cnt = 2'd0;
      if (pop_ok) begin
         case (idStepPc)
            2'd0:    pop_cnt = 2'd0;
            2'd1:    pop_cnt = 2'd1;
            default: pop_cnt = 2'd2;
         endcase
      end
      head1      = wrap_idx(int'(head) + 1);
      tail0      = wrap_idx(int'(head) + int'(count));
      tail1      = wrap_idx(int'(head) + int'(count) + 1);
      head_next  = wrap_idx(int'(head) + int'(pop_cnt));
      count_next = count + CW'(push_cnt) - CW'(pop_cnt);
      state_next = state;
      if (state == FLUSH) begin
         state_next = RUN;
      end
      if (xfer_err) begin
         state_next = FAULT;
      end
   end

   // Control FSM: reset beats redirect, redirect beats any same-edge ack/take.
   // memReq is registered from the post-edge state so a request is only ever
   // raised with at least two free slots in the queue.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= RUN;
         count      <= '0;
         head       <= '0;
         pc         <= RESET_PC;
         fetch_addr <= RESET_PC & ~32'd3;
         skip_low   <= RESET_PC[1];
         memReq     <= 1'b0;
      end else if (brValid) begin
         state      <= FLUSH;
         count      <= '0;
         head       <= '0;
         pc         <= brAddr & ~32'd1;
         fetch_addr <= brAddr & ~32'd3;
         skip_low   <= brAddr[1];
         memReq     <= 1'b0;
      end else begin
         state  <= state_next;
         count  <= count_next;
         head   <= head_next;
         pc     <= pc + {29'd0, pop_cnt, 1'b0};
         if (xfer_ok) begin
            fetch_addr <= fetch_addr + 32'd4;
            skip_low   <= 1'b0;
         end
         memReq <= (state_next == RUN) && (count_next <= CW'(QHW_DEPTH - 2));
      end
   end

   // Queue storage: write fetched halfwords at the tail; a misaligned start
   // drops the lower halfword of the first word.
   always_ff @(posedge clk) begin
      if (reset && !brValid && xfer_ok) begin
         if (skip_low) begin
            queue[tail0] <= memData[31:16];
         end else begin
            queue[tail0] <= memData[15:0];
            queue[tail1] <= memData[31:16];
         end
      end
   end

`ifdef IFETCH_STALL_CNT_EN
   logic [31:0] stall_q;

   // Saturating count of RUN cycles with nothing for the decoder.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_q <= 32'd0;
      end else if ((state == RUN) && !istrValid && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stallCnt = stall_q;
`else
   assign stallCnt = 32'd0;
`endif

endmodule

// File: tb/tb_ifetch_align.sv
// tb_ifetch_align: directed self-checking bench for ifetch_align.
// Inputs are driven and outputs sampled on the falling edge.
module tb_ifetch_align;

   logic        clk = 1'b0;
   logic        reset;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memAck;
   logic [31:0] memData;
   logic        memErr;
   logic [31:0] istrWord;
   logic        istrValid;
   logic [31:0] istrPc;
   logic        istrFault;
   logic        idTake;
   logic [1:0]  idStepPc;
   logic        brValid;
   logic [31:0] brAddr;
   logic [31:0] stallCnt;

   int errorCount = 0;
   int checkCount = 0;

`ifdef IFETCH_STALL_CNT_EN
   localparam logic [31:0] STALL_AT_END = 32'd10;
`else
   localparam logic [31:0] STALL_AT_END = 32'd0;
`endif

   ifetch_align #(
      .QHW_DEPTH(8),
      .RESET_PC (32'hA000_0000)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .memReq   (memReq),
      .memAddr  (memAddr),
      .memAck   (memAck),
      .memData  (memData),
      .memErr   (memErr),
      .istrWord (istrWord),
      .istrValid(istrValid),
      .istrPc   (istrPc),
      .istrFault(istrFault),
      .idTake   (idTake),
      .idStepPc (idStepPc),
      .brValid  (brValid),
      .brAddr   (brAddr),
      .stallCnt (stallCnt)
   );

   // 10-unit clock.
   always #5 clk = ~clk;

   // Count one comparison and report it if it disagrees.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, step one rising edge, return at the falling edge.
   task automatic applyStimulus(input logic take, input logic [1:0] step,
                                input logic ack, input logic err,
                                input logic [31:0] data, input logic br,
                                input logic [31:0] target);
      idTake   = take;
      idStepPc = step;
      memAck   = ack;
      memErr   = err;
      memData  = data;
      brValid  = br;
      brAddr   = target;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenario sequence.
   initial begin
      reset = 1'b0;
      idTake = 1'b0; idStepPc = 2'd0; memAck = 1'b0; memErr = 1'b0;
      memData = 32'd0; brValid = 1'b0; brAddr = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_memReq", {31'd0, memReq}, 32'd0);
      checkOutput("rst_valid", {31'd0, istrValid}, 32'd0);
      checkOutput("rst_word", istrWord, 32'd0);
      checkOutput("rst_fault", {31'd0, istrFault}, 32'd0);
      checkOutput("rst_pc", istrPc, 32'hA000_0000);
      checkOutput("rst_stall", stallCnt, 32'd0);

      // Reset release and first fetch.
      reset = 1'b1;
      applyStimulus(0, 2'd0, 0, 0, 32'd0, 0, 32'd0);
      checkOutput("req_after_rst", {31'd0, memReq}, 32'd1);
      checkOutput("addr_after_rst", memAddr, 32'hA000_0000);
      checkOutput("valid_empty", {31'd0, istrValid}, 32'd0);
      applyStimulus(0, 2'd0, 1, 0, 32'h0009_E301, 0, 32'd0);
      checkOutput("first_valid", {31'd0, istrValid}, 32'd1);
      checkOutput("first_word", istrWord, 32'h0009_E301);
      checkOutput("first_pc", istrPc, 32'hA000_0000);
      checkOutput("first_next_addr", memAddr, 32'hA000_0004);

      // 16-bit step leaves one halfword, window invalid until next push.
      applyStimulus(1, 2'd1, 0, 0, 32'd0, 0, 32'd0);
      checkOutput("step1_pc", istrPc, 32'hA000_0002);
      checkOutput("step1_valid", {31'd0, istrValid}, 32'd0);
      checkOutput("step1_word", istrWord, 32'd0);
      applyStimulus(0, 2'd0, 1, 0, 32'h5678_1234, 0, 32'd0);
      checkOutput("tail_word", istrWord, 32'h1234_0009);
      checkOutput("tail_valid", {31'd0, istrValid}, 32'd1);

      // 32-bit step: 3 -> 1 halfwords.
      applyStimulus(1, 2'd2, 0, 0, 32'd0, 0, 32'd0);
      checkOutput("step2_pc", istrPc, 32'hA000_0006);
      checkOutput("step2_valid", {31'd0, istrValid}, 32'd0);
      // Take while invalid is ignored; push lands.
      applyStimulus(1, 2'd2, 1, 0, 32'hDEF0_9ABC, 0, 32'd0);
      checkOutput("ign_take_pc", istrPc, 32'hA000_0006);
      checkOutput("ign_take_word", istrWord, 32'h9ABC_5678);
      checkOutput("ign_take_addr", memAddr, 32'hA000_000C);
      // Step 0 pops nothing, step 3 pops two.
      applyStimulus(1, 2'd0, 0, 0, 32'd0, 0, 32'd0);
      checkOutput("step0_pc", istrPc, 32'hA000_0006);
      checkOutput("step0_word", istrWord, 32'h9ABC_5678);
      applyStimulus(1, 2'd3, 0, 0, 32'd0, 0, 32'd0);
      checkOutput("step3_pc", istrPc, 32'hA000_000A);
      checkOutput("step3_valid", {31'd0, istrValid}, 32'd0);

      // Misaligned redirect on the same edge as an ack.
      applyStimulus(0, 2'd0, 1, 0, 32'h1111_2222, 1, 32'h8000_0012);
      checkOutput("br_req", {31'd0, memReq}, 32'd0);
      checkOutput("br_pc", istrPc, 32'h8000_0012);
      checkOutput("br_valid", {31'd0, istrValid}, 32'd0);
      applyStimulus(0, 2'd0, 0, 0, 32'd0, 0, 32'd0);
      checkOutput("br_req_back", {31'd0, memReq}, 32'd1);
      checkOutput("br_addr", memAddr, 32'h8000_0010);
      applyStimulus(0, 2'd0, 1, 0, 32'hAAAA_BBBB, 0, 32'd0);
      checkOutput("br_upper_only", {31'd0, istrValid}, 32'd0);
      checkOutput("br_addr2", memAddr, 32'h8000_0014);
      applyStimulus(0, 2'd0, 1, 0, 32'h4444_3333, 0, 32'd0);
      checkOutput("br_word", istrWord, 32'h3333_AAAA);
      checkOutput("br_word_pc", istrPc, 32'h8000_0012);

      // Fill the queue to 8 halfwords.
      applyStimulus(1, 2'd1, 1, 0, 32'h6666_5555, 0, 32'd0);
      checkOutput("fill_word", istrWord, 32'h4444_3333);
      checkOutput("fill_pc", istrPc, 32'h8000_0014);
      applyStimulus(0, 2'd0, 1, 0, 32'h8888_7777, 0, 32'd0);
      checkOutput("fill_req6", {31'd0, memReq}, 32'd1);
      applyStimulus(0, 2'd0, 1, 0, 32'hAAAA_9999, 0, 32'd0);
      checkOutput("full_req", {31'd0, memReq}, 32'd0);
      checkOutput("full_addr", memAddr, 32'h8000_0024);
      applyStimulus(0, 2'd0, 1, 0, 32'hFFFF_FFFF, 0, 32'd0);
      checkOutput("full_noovf_addr", memAddr, 32'h8000_0024);
      checkOutput("full_noovf_word", istrWord, 32'h4444_3333);
      applyStimulus(1, 2'd2, 1, 0, 32'hFFFF_FFFF, 0, 32'd0);
      checkOutput("unfull_req", {31'd0, memReq}, 32'd1);
      checkOutput("unfull_word", istrWord, 32'h6666_5555);
      checkOutput("unfull_pc", istrPc, 32'h8000_0018);
      applyStimulus(1, 2'd2, 0, 0, 32'd0, 0, 32'd0);
      checkOutput("drain_word1", istrWord, 32'h8888_7777);
      checkOutput("drain_pc1", istrPc, 32'h8000_001C);
      applyStimulus(1, 2'd2, 0, 0, 32'd0, 0, 32'd0);
      checkOutput("drain_word2", istrWord, 32'hAAAA_9999);
      checkOutput("drain_pc2", istrPc, 32'h8000_0020);

      // Fault: build 3 halfwords, then error on the 8000_0020 fetch.
      applyStimulus(0, 2'd0, 0, 0, 32'd0, 1, 32'h8000_001A);
      checkOutput("f_br_req", {31'd0, memReq}, 32'd0);
      checkOutput("f_br_pc", istrPc, 32'h8000_001A);
      applyStimulus(0, 2'd0, 0, 0, 32'd0, 0, 32'd0);
      checkOutput("f_req", {31'd0, memReq}, 32'd1);
      checkOutput("f_addr", memAddr, 32'h8000_0018);
      applyStimulus(0, 2'd0, 1, 0, 32'h5A5A_0F0F, 0, 32'd0);
      checkOutput("f_one_hw", {31'd0, istrValid}, 32'd0);
      applyStimulus(0, 2'd0, 1, 0, 32'h7B7B_6C6C, 0, 32'd0);
      checkOutput("f_word", istrWord, 32'h6C6C_5A5A);
      checkOutput("f_addr2", memAddr, 32'h8000_0020);
      applyStimulus(0, 2'd0, 1, 1, 32'hDEAD_DEAD, 0, 32'd0);
      checkOutput("err_req", {31'd0, memReq}, 32'd0);
      checkOutput("err_valid", {31'd0, istrValid}, 32'd1);
      checkOutput("err_fault_early", {31'd0, istrFault}, 32'd0);
      checkOutput("err_addr", memAddr, 32'h8000_0020);
      applyStimulus(1, 2'd2, 1, 0, 32'h1357_2468, 0, 32'd0);
      checkOutput("fault_set", {31'd0, istrFault}, 32'd1);
      checkOutput("fault_valid", {31'd0, istrValid}, 32'd0);
      checkOutput("fault_pc", istrPc, 32'h8000_001E);
      checkOutput("fault_req", {31'd0, memReq}, 32'd0);
      applyStimulus(0, 2'd0, 0, 0, 32'd0, 0, 32'd0);
      checkOutput("fault_hold", {31'd0, istrFault}, 32'd1);
      checkOutput("fault_hold_req", {31'd0, memReq}, 32'd0);
      applyStimulus(0, 2'd0, 0, 0, 32'd0, 1, 32'h8000_0040);
      checkOutput("fault_clr", {31'd0, istrFault}, 32'd0);
      checkOutput("fault_clr_req", {31'd0, memReq}, 32'd0);
      checkOutput("fault_clr_pc", istrPc, 32'h8000_0040);
      applyStimulus(0, 2'd0, 0, 0, 32'd0, 0, 32'd0);
      checkOutput("resume_req", {31'd0, memReq}, 32'd1);
      checkOutput("resume_addr", memAddr, 32'h8000_0040);
      applyStimulus(0, 2'd0, 1, 0, 32'hCAFE_BEEF, 0, 32'd0);
      checkOutput("resume_word", istrWord, 32'hCAFE_BEEF);
      checkOutput("resume_pc", istrPc, 32'h8000_0040);
      checkOutput("stall_count", stallCnt, STALL_AT_END);

      // Reset mid-transfer: the ack on the reset edge is ignored.
      reset = 1'b0;
      applyStimulus(0, 2'd0, 1, 0, 32'h1234_5678, 0, 32'd0);
      checkOutput("rst2_valid", {31'd0, istrValid}, 32'd0);
      checkOutput("rst2_word", istrWord, 32'd0);
      checkOutput("rst2_pc", istrPc, 32'hA000_0000);
      checkOutput("rst2_req", {31'd0, memReq}, 32'd0);
      checkOutput("rst2_stall", stallCnt, 32'd0);
      reset = 1'b1;
      applyStimulus(0, 2'd0, 0, 0, 32'd0, 0, 32'd0);
      checkOutput("rst2_addr", memAddr, 32'hA000_0000);
      checkOutput("rst2_req_on", {31'd0, memReq}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
